// File: rtl/free_ptr_alloc.sv
// ----------------------------------------------------------------------------
// free_ptr_alloc
//
// Client side of the free-pointer pool FIFO. Pops free pointers from the pool
// ahead of demand into a small prefetch buffer and offers the oldest one on a
// valid/ready allocate port. Released pointers arrive on a valid/ready release
// port and are pushed back into the pool one cycle later. Keeps a count of
// pointers held by clients and raises sticky accounting-error flags.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   pool_init_done     pool has finished loading its pointers
//   pool_empty/full    pool status
//   pool_rd_req        pop request; data valid on pool_rd_dout RD_LATENCY later
//   pool_rd_dout       popped pointer
//   pool_wr_req/din    push of a released pointer into the pool
//   alloc_valid/ptr    head of the prefetch buffer, taken when alloc_ready
//   rel_valid/ptr      pointer returned by a client, accepted when rel_ready
//   in_use             pointers currently held by clients
//   err_rel_underflow  sticky: release accepted while in_use == 0
//   err_pool_overflow  sticky: release accepted while pool_full
// ----------------------------------------------------------------------------
module free_ptr_alloc #(
  parameter int DATA_WIDTH     = 10,
  parameter int RD_LATENCY     = 2,
  parameter int PREFETCH_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pool_init_done,
  input  logic                  pool_empty,
  input  logic                  pool_full,
  output logic                  pool_rd_req,
  input  logic [DATA_WIDTH-1:0] pool_rd_dout,
  output logic                  pool_wr_req,
  output logic [DATA_WIDTH-1:0] pool_wr_din,
  output logic                  alloc_valid,
  output logic [DATA_WIDTH-1:0] alloc_ptr,
  input  logic                  alloc_ready,
  input  logic                  rel_valid,
  input  logic [DATA_WIDTH-1:0] rel_ptr,
  output logic                  rel_ready,
  output logic [DATA_WIDTH:0]   in_use,
  output logic                  err_rel_underflow,
  output logic                  err_pool_overflow
);

  // Counter width able to hold buffered + in-flight pointers.
  localparam int CW = $clog2(PREFETCH_DEPTH + RD_LATENCY + 1);
  localparam int AW = (PREFETCH_DEPTH > 1) ? $clog2(PREFETCH_DEPTH) : 1;

  // The buffer must cover the full pop round trip plus the one cycle an
  // alloc credit needs to come back, or back-to-back allocs stall.
  generate
    if (PREFETCH_DEPTH < RD_LATENCY + 2) begin : g_depth_check
      $error("free_ptr_alloc: PREFETCH_DEPTH must be >= RD_LATENCY + 2");
    end
    if (RD_LATENCY < 1) begin : g_latency_check
      $error("free_ptr_alloc: RD_LATENCY must be >= 1");
    end
  endgenerate

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [RD_LATENCY-1:0]   vsr_q;        // one bit per outstanding pop
  logic [CW-1:0]           inflight;
  logic [CW-1:0]           count_q;
  logic [AW-1:0]           wr_idx_q, rd_idx_q, rd_idx_inc;
  logic [DATA_WIDTH-1:0]   mem_q [PREFETCH_DEPTH];
  logic [DATA_WIDTH-1:0]   head_q;
  logic [DATA_WIDTH:0]     in_use_q;
  logic                    credit_ok;
  logic                    flush;
  logic                    rd_data_valid;
  logic                    buf_wr, buf_rd;
  logic                    alloc_hs, rel_hs;

  function automatic logic [AW-1:0] idx_inc(input logic [AW-1:0] idx);
    return (idx == AW'(PREFETCH_DEPTH - 1)) ? '0 : idx + AW'(1);
  endfunction

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    if (rst) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  // Losing pool_init_done while running means the pool is being reloaded:
  // everything prefetched or in flight is stale.
  assign flush = (state_q == S_RUN) && !pool_init_done;

  // --------------------------------------------------------------------------
  // Next state and handshake-side outputs
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    pool_rd_req = 1'b0;
    alloc_valid = 1'b0;
    rel_ready   = 1'b0;
    unique case (state_q)
      S_INIT: begin
        if (pool_init_done) state_d = S_RUN;
      end
      S_RUN: begin
        pool_rd_req = !pool_empty && credit_ok;
        alloc_valid = (count_q != '0);
        rel_ready   = 1'b1;
        if (!pool_init_done) state_d = S_INIT;
      end
      default: state_d = S_INIT;
    endcase
  end

  // --------------------------------------------------------------------------
  // Pop credit accounting
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: blocking assignments here because the accumulator must see its
    // own updated value on each loop iteration.
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CW'(vsr_q[i]);
    end
  end

  // Buffered plus outstanding pops may never exceed the buffer size, which
  // is what guarantees the buffer cannot overflow when the data lands.
  assign credit_ok = ({1'b0, inflight} + {1'b0, count_q}) < (CW + 1)'(PREFETCH_DEPTH);

  // Bit 0 marks a pop issued last cycle; the top bit marks the cycle its
  // data is on pool_rd_dout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        vsr_q <= '0;
    else if (flush) vsr_q <= '0;
    else            vsr_q <= (vsr_q << 1) | RD_LATENCY'(pool_rd_req);
  end

  assign rd_data_valid = vsr_q[RD_LATENCY-1];

  // --------------------------------------------------------------------------
  // Prefetch buffer: circular FIFO with a registered copy of the head entry
  // --------------------------------------------------------------------------
  assign alloc_hs   = alloc_valid && alloc_ready;
  assign rel_hs     = rel_valid && rel_ready;
  assign buf_wr     = rd_data_valid && !flush;
  assign buf_rd     = alloc_hs;
  assign rd_idx_inc = idx_inc(rd_idx_q);

  // NOTE: the storage array has no reset; count_q and head_q decide what is
  // valid, so clearing the entries would only cost reset routing.
  always_ff @(posedge clk) begin
    if (buf_wr) mem_q[wr_idx_q] <= pool_rd_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else if (flush) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (buf_wr) wr_idx_q <= idx_inc(wr_idx_q);
      if (buf_rd) rd_idx_q <= rd_idx_inc;

      unique case ({buf_wr, buf_rd})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      // The head must hold the oldest entry the cycle after any change. When
      // the buffer is about to be empty, the incoming word bypasses storage.
      if (buf_rd) begin
        if (count_q == CW'(1)) begin
          if (buf_wr) head_q <= pool_rd_dout;
        end else begin
          head_q <= mem_q[rd_idx_inc];
        end
      end else if (buf_wr && (count_q == '0)) begin
        head_q <= pool_rd_dout;
      end
    end
  end

  assign alloc_ptr = head_q;

  // --------------------------------------------------------------------------
  // Release path: registered push back into the pool
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pool_wr_req <= 1'b0;
      pool_wr_din <= '0;
    end else begin
      pool_wr_req <= rel_hs;
      if (rel_hs) pool_wr_din <= rel_ptr;
    end
  end

  // --------------------------------------------------------------------------
  // Held-pointer count and sticky error flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_use_q          <= '0;
      err_rel_underflow <= 1'b0;
      err_pool_overflow <= 1'b0;
    end else begin
      if (flush) begin
        in_use_q <= '0;
      end else begin
        unique case ({alloc_hs, rel_hs})
          2'b10: in_use_q <= in_use_q + (DATA_WIDTH + 1)'(1);
          2'b01: if (in_use_q != '0) in_use_q <= in_use_q - (DATA_WIDTH + 1)'(1);
          default: in_use_q <= in_use_q;
        endcase
      end
      // A release matched by an alloc in the same cycle nets to zero and is
      // not an underflow. The flags survive a pool reload.
      if (rel_hs && !alloc_hs && (in_use_q == '0)) err_rel_underflow <= 1'b1;
      // The push still goes out; the pool itself discards it.
      if (rel_hs && pool_full) err_pool_overflow <= 1'b1;
    end
  end

  assign in_use = in_use_q;

endmodule

// File: tb/tb_free_ptr_alloc.sv
// ----------------------------------------------------------------------------
// tb_free_ptr_alloc
//
// Self-checking bench for free_ptr_alloc. A behavioural pool (FIFO preloaded
// with 0..1023, two-cycle pop latency) surrounds the DUT. Expected alloc
// pointers, expected pool pushes and the held-pointer count come from the
// bench's own scoreboard and model; start-up timing comes from a vector table.
// ----------------------------------------------------------------------------
module tb_free_ptr_alloc;

  localparam int DW     = 10;
  localparam int LAT    = 2;
  localparam int DEPTH  = 4;
  localparam int POOL_N = 1 << DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pool_init_done = 1'b0;
  logic          pool_empty, pool_full;
  logic          pool_rd_req, pool_wr_req;
  logic [DW-1:0] pool_rd_dout, pool_wr_din;
  logic          alloc_valid;
  logic [DW-1:0] alloc_ptr;
  logic          alloc_ready = 1'b0;
  logic          rel_valid = 1'b0;
  logic [DW-1:0] rel_ptr = '0;
  logic          rel_ready;
  logic [DW:0]   in_use;
  logic          err_uf, err_of;

  free_ptr_alloc #(
    .DATA_WIDTH    (DW),
    .RD_LATENCY    (LAT),
    .PREFETCH_DEPTH(DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pool_init_done   (pool_init_done),
    .pool_empty       (pool_empty),
    .pool_full        (pool_full),
    .pool_rd_req      (pool_rd_req),
    .pool_rd_dout     (pool_rd_dout),
    .pool_wr_req      (pool_wr_req),
    .pool_wr_din      (pool_wr_din),
    .alloc_valid      (alloc_valid),
    .alloc_ptr        (alloc_ptr),
    .alloc_ready      (alloc_ready),
    .rel_valid        (rel_valid),
    .rel_ptr          (rel_ptr),
    .rel_ready        (rel_ready),
    .in_use           (in_use),
    .err_rel_underflow(err_uf),
    .err_pool_overflow(err_of)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Behavioural pool: pop at edge t -> stage -> dout valid in cycle t+2
  // --------------------------------------------------------------------------
  logic [DW-1:0] pool_q[$];
  logic [DW-1:0] pool_pipe;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pool_q.delete();
      for (int i = 0; i < POOL_N; i++) pool_q.push_back(DW'(i));
      pool_pipe    <= '0;
      pool_rd_dout <= '0;
      pool_empty   <= 1'b0;
      pool_full    <= 1'b1;
    end else begin
      if (pool_rd_req && pool_q.size() != 0) pool_pipe <= pool_q.pop_front();
      if (pool_wr_req && pool_q.size() < POOL_N) pool_q.push_back(pool_wr_din);
      pool_rd_dout <= pool_pipe;
      pool_empty   <= (pool_q.size() == 0);
      pool_full    <= (pool_q.size() == POOL_N);
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard state
  // --------------------------------------------------------------------------
  int            tests = 0;
  int            fails = 0;
  int            cyc   = 0;
  logic [DW-1:0] exp_q[$];    // pointers in the order they must be allocated
  logic [DW-1:0] wr_exp[$];   // pointers that must appear on pool_wr_din
  logic [DW-1:0] held[$];     // pointers currently held by the bench client
  bit            wr_pending;
  int            model_in_use;
  bit            exp_uf, exp_of;
  bit            a_hs;
  logic [DW-1:0] a_ptr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_msg(input string name);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic sb_reset();
    exp_q.delete();
    for (int i = 0; i < POOL_N; i++) exp_q.push_back(DW'(i));
    wr_exp.delete();
    held.delete();
    wr_pending   = 1'b0;
    model_in_use = 0;
    exp_uf       = 1'b0;
    exp_of       = 1'b0;
    a_hs         = 1'b0;
  endtask

  // Assert reset mid-cycle, check the outputs clear at once, release on a
  // falling edge.
  task automatic do_reset();
    rst            = 1'b1;
    pool_init_done = 1'b0;
    alloc_ready    = 1'b0;
    rel_valid      = 1'b0;
    #1;
    check("rst_ctrl", 32'({pool_rd_req, pool_wr_req, alloc_valid, rel_ready, err_uf, err_of}), 32'd0);
    check("rst_wr_din", 32'(pool_wr_din), 32'd0);
    check("rst_alloc_ptr", 32'(alloc_ptr), 32'd0);
    check("rst_in_use", 32'(in_use), 32'd0);
    sb_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: check registered outputs, drive inputs, record the
  // handshakes that will happen at the coming rising edge.
  task automatic step(input logic init, input logic a_rdy, input logic r_val,
                      input logic [DW-1:0] r_ptr);
    logic [DW-1:0] e;
    @(negedge clk);
    cyc++;
    check("in_use", 32'(in_use), 32'(model_in_use));
    check("err_flags", 32'({err_uf, err_of}), 32'({exp_uf, exp_of}));
    if (wr_pending) begin
      e = wr_exp.pop_front();
      check("pool_wr_req", 32'(pool_wr_req), 32'd1);
      check("pool_wr_din", 32'(pool_wr_din), 32'(e));
    end else if (pool_wr_req) begin
      check("pool_wr_req_spurious", 32'(pool_wr_req), 32'd0);
    end

    pool_init_done = init;
    alloc_ready    = a_rdy;
    rel_valid      = r_val;
    rel_ptr        = r_ptr;
    #1;

    a_hs = alloc_valid && alloc_ready;
    a_ptr = alloc_ptr;
    if (a_hs) begin
      if (exp_q.size() == 0) fail_msg("alloc_unexpected");
      else check("alloc_ptr", 32'(alloc_ptr), 32'(exp_q.pop_front()));
      held.push_back(alloc_ptr);
    end
    if (rel_valid && rel_ready) begin
      exp_q.push_back(r_ptr);
      wr_exp.push_back(r_ptr);
      if (!a_hs && model_in_use == 0) exp_uf = 1'b1;
      if (pool_full) exp_of = 1'b1;
      if (!a_hs && model_in_use != 0) model_in_use--;
    end else if (a_hs) begin
      model_in_use++;
    end
    if (!init) model_in_use = 0;
    wr_pending = rel_valid && rel_ready;
  endtask

  typedef struct {
    logic          init;
    logic          rdy;
    logic          rd_req;
    logic          av;
    logic          rr;
    logic [DW-1:0] ptr;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #500000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int pops, guard, start_in_use, n_alloc, fall_cyc, hs_cyc;
    bit got;

    // pool_init_done rises in cycle 1: first pop in cycle 2, first alloc in 5.
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 10'd0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 10'd0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 10'd0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd2};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd3};

    #2;
    // ---- Start-up timing from the vector table -----------------------------
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].init, tbl[i].rdy, 1'b0, '0);
      check($sformatf("tbl%0d_rd_req", i), 32'(pool_rd_req), 32'(tbl[i].rd_req));
      check($sformatf("tbl%0d_alloc_valid", i), 32'(alloc_valid), 32'(tbl[i].av));
      check($sformatf("tbl%0d_rel_ready", i), 32'(rel_ready), 32'(tbl[i].rr));
      if (tbl[i].av) check($sformatf("tbl%0d_alloc_ptr", i), 32'(alloc_ptr), 32'(tbl[i].ptr));
    end

    // ---- alloc_ready low: exactly PREFETCH_DEPTH pops, then stable --------
    do_reset();
    pops = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      if (pool_rd_req) pops++;
    end
    check("hold_pop_count", 32'(pops), 32'(DEPTH));
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      check("hold_rd_req", 32'(pool_rd_req), 32'd0);
      check("hold_alloc_valid", 32'(alloc_valid), 32'd1);
      check("hold_alloc_ptr", 32'(alloc_ptr), 32'd0);
    end

    // ---- Drain the whole pool, then recycle one pointer -------------------
    do_reset();
    guard = 0;
    while (exp_q.size() != 0 && guard < 1200) begin
      step(1'b1, 1'b1, 1'b0, '0);
      guard++;
    end
    if (exp_q.size() != 0) fail_msg("drain_timeout");
    repeat (3) step(1'b1, 1'b1, 1'b0, '0);
    check("drain_alloc_valid", 32'(alloc_valid), 32'd0);
    check("drain_rd_req", 32'(pool_rd_req), 32'd0);
    check("drain_in_use", 32'(in_use), 32'(POOL_N));
    step(1'b1, 1'b1, 1'b1, 10'h155);
    fall_cyc = -1;
    hs_cyc   = -1;
    for (int i = 0; i < 20 && hs_cyc < 0; i++) begin
      step(1'b1, 1'b1, 1'b0, '0);
      if (fall_cyc < 0 && !pool_empty) fall_cyc = cyc;
      if (a_hs) begin
        hs_cyc = cyc;
        check("recycle_ptr", 32'(a_ptr), 32'h155);
      end
    end
    if (hs_cyc < 0 || fall_cyc < 0) fail_msg("recycle_timeout");
    else check("recycle_latency_ok", 32'(hs_cyc - fall_cyc <= LAT + 2), 32'd1);
    step(1'b1, 1'b0, 1'b0, '0);
    check("recycle_in_use", 32'(in_use), 32'(POOL_N));

    // ---- Simultaneous alloc and release every cycle -----------------------
    do_reset();
    guard = 0;
    while (held.size() < 8 && guard < 50) begin
      step(1'b1, 1'b1, 1'b0, '0);
      guard++;
    end
    if (held.size() < 8) fail_msg("fill_timeout");
    step(1'b1, 1'b0, 1'b0, '0);
    start_in_use = model_in_use;
    n_alloc = 0;
    for (int i = 0; i < 100; i++) begin
      if (held.size() != 0) step(1'b1, 1'b1, 1'b1, held.pop_front());
      else                  step(1'b1, 1'b1, 1'b0, '0);
      if (a_hs) n_alloc++;
    end
    step(1'b1, 1'b0, 1'b0, '0);
    check("steady_allocs", 32'(n_alloc), 32'd100);
    check("steady_in_use", 32'(in_use), 32'(start_in_use));
    check("steady_errors", 32'({err_uf, err_of}), 32'd0);

    // ---- Release with nothing held (also while the pool is full) ----------
    do_reset();
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 10'h2AA);
    step(1'b1, 1'b0, 1'b0, '0);
    check("uf_flag", 32'(err_uf), 32'd1);
    check("of_flag", 32'(err_of), 32'd1);
    check("uf_in_use", 32'(in_use), 32'd0);
    repeat (4) step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    check("reinit_alloc_valid", 32'(alloc_valid), 32'd0);
    check("reinit_flags_kept", 32'({err_uf, err_of}), 32'b11);

    // ---- Reset with pops in flight and entries buffered -------------------
    do_reset();
    step(1'b0, 1'b0, 1'b0, '0);
    guard = 0;
    while (held.size() < 3 && guard < 20) begin
      step(1'b1, 1'b1, 1'b0, '0);
      guard++;
    end
    step(1'b1, 1'b0, 1'b0, '0);
    check("pre_reset_buffered", 32'(alloc_valid), 32'd1);
    check("pre_reset_inflight", 32'(dut.vsr_q != '0), 32'd1);
    do_reset();
    step(1'b0, 1'b0, 1'b0, '0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b1, 1'b1, 1'b0, '0);
      if (a_hs) begin
        got = 1'b1;
        check("post_reset_first_ptr", 32'(a_ptr), 32'd0);
      end
    end
    if (!got) fail_msg("post_reset_timeout");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
